// File: rtl/tmr_pkg.sv
// Shared TMR definitions: replica count, default data width, controller states.
package tmr_pkg;
    localparam int         NUM_REPLICAS   = 3;
    localparam int         DEFAULT_WIDTH  = 8;
    localparam logic [1:0] TARGET_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_INJECT,
        ST_OBSERVE,
        ST_REPORT
    } state_t;
endpackage

// File: rtl/replica_compare.sv
// Compares each replica against the voter output, split into the corrupted
// replica and the two replicas that are expected to stay healthy.
module replica_compare
    import tmr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rep0,
    input  logic [WIDTH-1:0] rep1,
    input  logic [WIDTH-1:0] rep2,
    input  logic [WIDTH-1:0] voted,
    input  logic [1:0]       target,
    output logic             target_mismatch,
    output logic             healthy_mismatch
);
    always_comb begin
        target_mismatch  = 1'b0;
        healthy_mismatch = 1'b0;
        case (target)
            2'd0: begin
                target_mismatch  = (rep0 != voted);
                healthy_mismatch = (rep1 != voted) || (rep2 != voted);
            end
            2'd1: begin
                target_mismatch  = (rep1 != voted);
                healthy_mismatch = (rep0 != voted) || (rep2 != voted);
            end
            2'd2: begin
                target_mismatch  = (rep2 != voted);
                healthy_mismatch = (rep0 != voted) || (rep1 != voted);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/fault_inject_ctrl.sv
// Single-shot fault injection into one TMR replica, followed by an observation
// window that checks whether the voter masked the upset.
module fault_inject_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int OBS_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              target_sel,
    input  logic [WIDTH-1:0]        bit_mask,
    input  logic [WIDTH-1:0]        rep0,
    input  logic [WIDTH-1:0]        rep1,
    input  logic [WIDTH-1:0]        rep2,
    input  logic [WIDTH-1:0]        voted,
    output logic [WIDTH-1:0]        inj_data,
    output logic [NUM_REPLICAS-1:0] inj_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    masked,
    output logic [7:0]              mismatch_cycles,
    output logic [15:0]             total_runs,
    output logic [15:0]             total_unmasked
);
    localparam logic [7:0] OBS_LAST = 8'(OBS_CYCLES - 1);

    state_t           state, state_next;
    logic [1:0]       tgt_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] rep_tgt;
    logic [7:0]       win;
    logic [7:0]       mm_cnt, mm_next;
    logic             voter_fail, vf_next;
    logic             target_mismatch, healthy_mismatch;

    replica_compare #(.WIDTH(WIDTH)) u_cmp (
        .rep0            (rep0),
        .rep1            (rep1),
        .rep2            (rep2),
        .voted           (voted),
        .target          (tgt_q),
        .target_mismatch (target_mismatch),
        .healthy_mismatch(healthy_mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start && target_sel != TARGET_INVALID) state_next = ST_ARM;
            ST_ARM:     state_next = ST_INJECT;
            ST_INJECT:  state_next = ST_OBSERVE;
            ST_OBSERVE: if (win == OBS_LAST) state_next = ST_REPORT;
            ST_REPORT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_REPORT);
    end

    always_comb begin
        case (tgt_q)
            2'd0:    rep_tgt = rep0;
            2'd1:    rep_tgt = rep1;
            default: rep_tgt = rep2;
        endcase
    end

    // Strobe and data are registered on entry to INJECT so they are live for that cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_en   <= '0;
            inj_data <= '0;
        end else if (state_next == ST_INJECT) begin
            inj_en   <= {{(NUM_REPLICAS-1){1'b0}}, 1'b1} << tgt_q;
            inj_data <= rep_tgt ^ mask_q;
        end else begin
            inj_en   <= '0;
            inj_data <= '0;
        end
    end

    always_comb begin
        mm_next = (target_mismatch && mm_cnt != 8'hFF) ? mm_cnt + 8'd1 : mm_cnt;
        vf_next = voter_fail | healthy_mismatch;
    end

    // Results are published on the last observe edge so they are valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q           <= '0;
            mask_q          <= '0;
            win             <= '0;
            mm_cnt          <= '0;
            voter_fail      <= 1'b0;
            err             <= 1'b0;
            masked          <= 1'b1;
            mismatch_cycles <= '0;
            total_runs      <= '0;
            total_unmasked  <= '0;
        end else begin
            err <= (state == ST_IDLE) && start && (target_sel == TARGET_INVALID);
            case (state)
                ST_IDLE: if (state_next == ST_ARM) begin
                    tgt_q      <= target_sel;
                    mask_q     <= bit_mask;
                    mm_cnt     <= '0;
                    voter_fail <= 1'b0;
                end
                ST_INJECT: win <= '0;
                ST_OBSERVE: begin
                    win        <= win + 8'd1;
                    mm_cnt     <= mm_next;
                    voter_fail <= vf_next;
                    if (state_next == ST_REPORT) begin
                        masked          <= ~vf_next;
                        mismatch_cycles <= mm_next;
                        total_runs      <= total_runs + 16'd1;
                        if (vf_next && total_unmasked != 16'hFFFF)
                            total_unmasked <= total_unmasked + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fault_inject_ctrl.sv
// Randomized scoreboard bench for fault_inject_ctrl: stimulus pushes expected
// injections/results, a negedge monitor pops and compares them.
module tb_fault_inject_ctrl;
    import tmr_pkg::*;

    localparam int W   = 8;
    localparam int OBS = 16;

    logic         clk = 1'b0;
    logic         rst, start, start1;
    logic [1:0]   target_sel;
    logic [W-1:0] bit_mask, rep0, rep1, rep2, voted;

    logic [W-1:0] inj_data, inj_data1;
    logic [2:0]   inj_en, inj_en1;
    logic         busy, done, err, masked, busy1, done1, err1, masked1;
    logic [7:0]   mismatch_cycles, mismatch_cycles1;
    logic [15:0]  total_runs, total_unmasked, total_runs1, total_unmasked1;

    fault_inject_ctrl #(.WIDTH(W), .OBS_CYCLES(OBS)) dut (
        .clk(clk), .rst(rst), .start(start), .target_sel(target_sel), .bit_mask(bit_mask),
        .rep0(rep0), .rep1(rep1), .rep2(rep2), .voted(voted),
        .inj_data(inj_data), .inj_en(inj_en), .busy(busy), .done(done), .err(err),
        .masked(masked), .mismatch_cycles(mismatch_cycles),
        .total_runs(total_runs), .total_unmasked(total_unmasked)
    );

    fault_inject_ctrl #(.WIDTH(W), .OBS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .target_sel(target_sel), .bit_mask(bit_mask),
        .rep0(rep0), .rep1(rep1), .rep2(rep2), .voted(voted),
        .inj_data(inj_data1), .inj_en(inj_en1), .busy(busy1), .done(done1), .err(err1),
        .masked(masked1), .mismatch_cycles(mismatch_cycles1),
        .total_runs(total_runs1), .total_unmasked(total_unmasked1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [2:0] en; logic [7:0] data; } inj_exp_t;
    typedef struct { int done_cyc; logic msk; logic [7:0] mm; logic [15:0] runs, unm; } res_exp_t;
    inj_exp_t inj_q[$];
    res_exp_t res_q[$];
    int       err_q[$];

    inj_exp_t m_inj;
    res_exp_t m_res;
    int       m_err;

    // Monitor: every output event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (inj_en != 3'b000) begin
                if (inj_q.size() == 0) chk("inj_unexpected", {29'd0, inj_en}, 32'd0);
                else begin
                    m_inj = inj_q.pop_front();
                    chk("inj_en", {29'd0, inj_en}, {29'd0, m_inj.en});
                    chk("inj_data", {24'd0, inj_data}, {24'd0, m_inj.data});
                end
            end else chk("inj_data_idle", {24'd0, inj_data}, 32'd0);
            if (done) begin
                if (res_q.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
                else begin
                    m_res = res_q.pop_front();
                    chk("done_cycle", cyc, m_res.done_cyc);
                    chk("done_busy", {31'd0, busy}, 32'd1);
                    chk("masked", {31'd0, masked}, {31'd0, m_res.msk});
                    chk("mismatch_cycles", {24'd0, mismatch_cycles}, {24'd0, m_res.mm});
                    chk("total_runs", {16'd0, total_runs}, {16'd0, m_res.runs});
                    chk("total_unmasked", {16'd0, total_unmasked}, {16'd0, m_res.unm});
                end
            end
            if (err) begin
                if (err_q.size() == 0) chk("err_unexpected", {31'd0, err}, 32'd0);
                else begin
                    m_err = err_q.pop_front();
                    chk("err_cycle", cyc, m_err);
                end
            end
        end
    end

    // Per-cycle input plan for one run: index k is the value sampled at start edge + k.
    logic [W-1:0] a0[0:OBS+3], a1[0:OBS+3], a2[0:OBS+3], av[0:OBS+3];
    logic [15:0]  exp_runs = 0, exp_unm = 0;

    function automatic logic [W-1:0] rsel(input int t, input int k);
        case (t)
            0:       return a0[k];
            1:       return a1[k];
            default: return a2[k];
        endcase
    endfunction

    task automatic apply(input int k);
        rep0 = a0[k]; rep1 = a1[k]; rep2 = a2[k]; voted = av[k];
    endtask

    task automatic gen(input int mode);
        logic [W-1:0] base, nz;
        base = 8'($urandom);
        for (int k = 0; k <= OBS + 3; k++) begin
            if (mode == 3) begin
                a0[k] = base; a1[k] = base; a2[k] = base; av[k] = base;
                if ($urandom_range(0, 2) == 0) begin
                    nz = 8'($urandom_range(1, 255));
                    case ($urandom_range(0, 3))
                        0: a0[k] = base ^ nz;
                        1: a1[k] = base ^ nz;
                        2: a2[k] = base ^ nz;
                        default: av[k] = base ^ nz;
                    endcase
                end
            end else begin
                a0[k] = 8'h10; a1[k] = 8'h10; a2[k] = 8'h10; av[k] = 8'h10;
                if (mode == 1 && k >= 3) a1[k] = 8'h11;
                if (mode == 2 && k >= 3 && k <= 5) begin a1[k] = 8'h22; av[k] = 8'h22; end
            end
        end
    endtask

    // Must be called at a negedge; returns at a negedge with the DUT idle.
    task automatic do_run(input int t, input logic [W-1:0] mask, input int mode,
                          input bit extra_start, input bit abort);
        inj_exp_t ie;
        res_exp_t re;
        int mm, n;
        bit vf;
        gen(mode);
        ie.en = 3'(1 << t);
        ie.data = rsel(t, 1) ^ mask;
        inj_q.push_back(ie);
        mm = 0; vf = 0;
        for (int k = 3; k <= OBS + 2; k++) begin
            if (rsel(t, k) != av[k] && mm < 255) mm++;
            for (int j = 0; j < 3; j++)
                if (j != t && rsel(j, k) != av[k]) vf = 1;
        end
        if (!abort) begin
            exp_runs = exp_runs + 16'd1;
            if (vf && exp_unm != 16'hFFFF) exp_unm = exp_unm + 16'd1;
            re.done_cyc = cyc + 3 + OBS;
            re.msk = !vf; re.mm = 8'(mm); re.runs = exp_runs; re.unm = exp_unm;
            res_q.push_back(re);
        end
        start = 1'b1; target_sel = 2'(t); bit_mask = mask; apply(0);
        for (int k = 1; k <= OBS + 2; k++) begin
            @(negedge clk);
            start = extra_start && (k == 6);
            target_sel = extra_start ? 2'd3 : 2'(t);
            bit_mask = 8'($urandom);
            apply(k);
            if (abort && k == 2) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_inj_en", {29'd0, inj_en}, 32'd0);
                chk("abort_inj_data", {24'd0, inj_data}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_masked", {31'd0, masked}, 32'd1);
                chk("abort_runs", {16'd0, total_runs}, 32'd0);
                exp_runs = 0; exp_unm = 0;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                return;
            end
        end
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("run_timeout", n < 50 ? 32'd0 : 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int c0, n;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; target_sel = 2'd0; bit_mask = '0;
        rep0 = '0; rep1 = '0; rep2 = '0; voted = '0;
        repeat (2) @(negedge clk);
        chk("rst_inj_en", {29'd0, inj_en}, 32'd0);
        chk("rst_inj_data", {24'd0, inj_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_masked", {31'd0, masked}, 32'd1);
        chk("rst_mm", {24'd0, mismatch_cycles}, 32'd0);
        chk("rst_runs", {16'd0, total_runs}, 32'd0);
        chk("rst_unm", {16'd0, total_unmasked}, 32'd0);
        rst = 1'b0;
        do_run(1, 8'h01, 0, 0, 0);     // clean run, first edge after reset
        do_run(1, 8'h01, 1, 0, 0);     // target stays corrupted for the window
        do_run(1, 8'h05, 2, 0, 0);     // voter follows the corrupted replica
        // Invalid target: err pulse only, no run.
        start = 1'b1; target_sel = 2'd3; err_q.push_back(cyc + 1);
        @(negedge clk); start = 1'b0;
        chk("err_busy0", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("err_busy1", {31'd0, busy}, 32'd0);
        chk("err_single", {31'd0, err}, 32'd0);
        do_run(2, 8'h00, 0, 1, 0);     // zero mask plus ignored start while busy
        do_run(0, 8'hA5, 0, 0, 1);     // reset during INJECT
        do_run(0, 8'h3C, 3, 0, 0);     // must start on the first edge after reset
        // OBS_CYCLES=1 build: 4-cycle latency.
        gen(0); apply(0);
        start1 = 1'b1; c0 = cyc;
        @(negedge clk); start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin @(negedge clk); n++; end
        chk("obs1_latency", cyc - c0, 32'd4);
        chk("obs1_runs", {16'd0, total_runs1}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 20; i++)
            do_run(int'($urandom_range(0, 2)), 8'($urandom), 3, 0, 0);
        repeat (3) @(negedge clk);
        chk("inj_q_empty", inj_q.size(), 32'd0);
        chk("res_q_empty", res_q.size(), 32'd0);
        chk("err_q_empty", err_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks %0d, failures %0d)", n_chk, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/fault_inject_ctrl.md
FAULT_INJECT_CTRL -- requirements
Module: fault_inject_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: replica data width.
REQ-002 SHALL have parameter OBS_CYCLES, default 16: observation window length in cycles, range 1..255.
REQ-003 SHALL have ports clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request one injection run; sampled in IDLE only.
REQ-006 SHALL have port target_sel, input, 2: replica to corrupt (0..2); 3 is invalid.
REQ-007 SHALL have port bit_mask, input, WIDTH: bits to flip in the target replica.
REQ-008 SHALL have ports rep0, rep1, rep2, input, WIDTH each: replica counter values.
REQ-009 SHALL have port voted, input, WIDTH: voter output.
REQ-010 SHALL have port inj_data, output, WIDTH: value forced into the target replica.
REQ-011 SHALL have port inj_en, output, 3: one-hot per-replica injection strobe.
REQ-012 SHALL have ports busy and done, output, 1 each: run in progress; one-cycle run-complete pulse.
REQ-013 SHALL have port err, output, 1: one-cycle pulse on start with target_sel==3.
REQ-014 SHALL have ports masked and mismatch_cycles, output, 1 and 8: last-run result.
REQ-015 SHALL have ports total_runs and total_unmasked, output, 16 each: campaign counters.

Function
REQ-016 SHALL implement FSM IDLE -> ARM -> INJECT -> OBSERVE -> REPORT -> IDLE.
REQ-017 IDLE: start=1 with target_sel<3 SHALL move to ARM and latch target_sel and bit_mask; start with target_sel==3 SHALL pulse err next cycle and stay IDLE.
REQ-018 ARM SHALL last exactly one cycle.
REQ-019 INJECT SHALL last exactly one cycle, driving inj_en[target]=1 and inj_data = rep[target] XOR latched mask, both registered outputs.
REQ-020 inj_en SHALL be 3'b000 and inj_data SHALL be 0 in every state other than INJECT.
REQ-021 OBSERVE SHALL last exactly OBS_CYCLES cycles, counted by an 8-bit window counter.
REQ-022 Each OBSERVE cycle with rep[target] != voted SHALL increment mismatch_cycles, saturating at 255.
REQ-023 Each OBSERVE cycle with either non-target replica != voted SHALL set a sticky voter_fail flag.
REQ-024 REPORT SHALL last one cycle: done=1, masked = NOT voter_fail, total_runs += 1 (wraps at 65535->0), total_unmasked += 1 if voter_fail (saturates at 65535).
REQ-025 busy SHALL be 1 in ARM, INJECT, OBSERVE and REPORT, and 0 in IDLE.
REQ-026 start asserted while busy SHALL be ignored, with no queuing.
REQ-027 bit_mask==0 SHALL still execute a full run; inj_en pulses with unchanged data.
REQ-028 mismatch_cycles and voter_fail SHALL clear on entry to ARM; masked and mismatch_cycles SHALL hold last-run values until the next REPORT.
REQ-029 Start-to-done latency SHALL be 3 + OBS_CYCLES cycles: start sampled at edge N, done high during cycle N+3+OBS_CYCLES.

Reset
REQ-030 rst SHALL asynchronously force IDLE, inj_en=0, inj_data=0, busy=0, done=0, err=0, masked=1, mismatch_cycles=0, total_runs=0 and total_unmasked=0.
REQ-031 rst asserted mid-run, including during INJECT, SHALL drop inj_en within the same cycle, abort the run and not update the counters.
REQ-032 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 Shared package tmr_pkg SHALL hold NUM_REPLICAS=3, the default WIDTH, the FSM state enumeration and TARGET_INVALID=2'd3.
REQ-034 Comparison logic SHALL be a sub-module, replica_compare (inputs: three replicas, voted and target; outputs: target_mismatch and healthy_mismatch), combinational and instanced once.
REQ-035 The FSM, window counter and statistics SHALL reside in fault_inject_ctrl.

Verification
REQ-036 Start with target=1, mask=8'h01, rep0..2=voted=8'h10 -> inj_en=3'b010 and inj_data=8'h11 for exactly one cycle; done at 3+16 cycles after start; masked=1; total_runs=1.
REQ-037 Same run with the bench holding rep1=8'h11 and the others at 8'h10 for the window -> mismatch_cycles=16, masked=1, total_unmasked=0.
REQ-038 Bench forcing voted=rep1 != rep0 for 3 OBSERVE cycles -> masked=0, total_unmasked increments by 1.
REQ-039 Start with target_sel=3 -> err pulses once, busy stays 0, inj_en stays 0; second start during busy -> ignored, one done only.
REQ-040 rst pulsed during INJECT -> inj_en=0 same cycle, all outputs at reset values, next start completes normally.
REQ-041 Preload total_runs=16'hFFFF via 65535 runs (or force) then one run -> total_runs=0; OBS_CYCLES=1 build -> latency 4.
